// File: rtl/if_fetch_unit_pkg.sv
// Shared configuration for the instruction-fetch stage: widths, state encodings
// and the sequential word increment.
package if_fetch_unit_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam int INSTR_LEN   = 32;
  localparam int WORD_INCR   = 4;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,
    IF_HOLD    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  // Modulo add: the top word wraps back to address 0.
  function automatic logic [ADDRESS_LEN-1:0] next_word(input logic [ADDRESS_LEN-1:0] addr);
    return addr + ADDRESS_LEN'(WORD_INCR);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the memory (slave).
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  // Handshake: the master raises req with a stable addr and keeps both unchanged
  // until the slave answers with ready=1; rdata is valid only in that cycle and
  // ready is meaningless whenever req is low.
  logic                   req;
  logic [ADDRESS_LEN-1:0] addr;
  logic                   ready;
  logic [INSTR_LEN-1:0]   rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );

endinterface

// File: rtl/if_fetch_unit_output_reg.sv
// IF output register feeding the ID stage: {pc_out, instruction, instr_valid}.
// Priority is async reset, then flush (valid cleared, payload kept), then load.
module if_output_reg
  import if_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   load,
  input  logic [ADDRESS_LEN-1:0] load_pc,
  input  logic [INSTR_LEN-1:0]   load_instr,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [INSTR_LEN-1:0]   instruction,
  output logic                   instr_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out      <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      pc_out      <= load_pc;
      instruction <= load_instr;
      instr_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready bus, absorbs a
// freeze with a one-entry skid and redirects on branch_taken.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  if_fetch_unit_if.master        imem,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic [INSTR_LEN-1:0]   instruction,
  output logic                   instr_valid,
  output if_state_e              fsm_state
);

  if_state_e              state, state_next;
  logic [ADDRESS_LEN-1:0] pc, pc_next;
  logic [ADDRESS_LEN-1:0] skid_pc, skid_pc_next;
  logic [INSTR_LEN-1:0]   skid_instr, skid_instr_next;
  logic [ADDRESS_LEN-1:0] redirect_pc, redirect_pc_next;

  logic                   out_flush;
  logic                   out_load;
  logic [ADDRESS_LEN-1:0] out_pc;
  logic [INSTR_LEN-1:0]   out_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IF_FETCH;
      pc          <= RESET_PC;
      skid_pc     <= '0;
      skid_instr  <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      skid_pc     <= skid_pc_next;
      skid_instr  <= skid_instr_next;
      redirect_pc <= redirect_pc_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    skid_pc_next     = skid_pc;
    skid_instr_next  = skid_instr;
    redirect_pc_next = redirect_pc;
    out_flush        = 1'b0;
    out_load         = 1'b0;
    out_pc           = next_word(pc);
    out_instr        = imem.rdata;

    if (branch_taken) begin
      // Redirect overrides freeze. The pc is only retargeted once no fetch is
      // outstanding, so imem.addr never moves under an unanswered request.
      out_flush       = 1'b1;
      skid_pc_next    = '0;
      skid_instr_next = '0;
      unique case (state)
        IF_FETCH: begin
          if (imem.ready) begin
            pc_next    = branch_addr;
            state_next = IF_FETCH;
          end else begin
            redirect_pc_next = branch_addr;
            state_next       = IF_DISCARD;
          end
        end
        IF_HOLD: begin
          pc_next    = branch_addr;
          state_next = IF_FETCH;
        end
        IF_DISCARD: begin
          redirect_pc_next = branch_addr;
          if (imem.ready) begin
            pc_next    = branch_addr;
            state_next = IF_FETCH;
          end
        end
        default: state_next = IF_FETCH;
      endcase
    end else begin
      unique case (state)
        IF_FETCH: begin
          if (imem.ready) begin
            pc_next = next_word(pc);
            if (freeze) begin
              skid_pc_next    = next_word(pc);
              skid_instr_next = imem.rdata;
              state_next      = IF_HOLD;
            end else begin
              out_load = 1'b1;
            end
          end else if (!freeze) begin
            out_flush = 1'b1;
          end
        end
        IF_HOLD: begin
          if (!freeze) begin
            out_load   = 1'b1;
            out_pc     = skid_pc;
            out_instr  = skid_instr;
            state_next = IF_FETCH;
          end
        end
        IF_DISCARD: begin
          if (imem.ready) begin
            pc_next    = redirect_pc;
            state_next = IF_FETCH;
          end
        end
        default: state_next = IF_FETCH;
      endcase
    end
  end

  // No request while the skid is occupied; the address is simply the PC.
  assign imem.req  = (state != IF_HOLD);
  assign imem.addr = pc;
  assign fsm_state = state;

  if_output_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (out_flush),
    .load        (out_load),
    .load_pc     (out_pc),
    .load_instr  (out_instr),
    .pc_out      (pc_out),
    .instruction (instruction),
    .instr_valid (instr_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory model, program-order stream
// scoreboard consumed by the ID-side monitor, directed cases and a random phase.
module tb_if_fetch_unit
  import if_fetch_unit_pkg::*;
;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                   freeze;
  logic                   branch_taken;
  logic [ADDRESS_LEN-1:0] branch_addr;
  logic [ADDRESS_LEN-1:0] pc_out;
  logic [INSTR_LEN-1:0]   instruction;
  logic                   instr_valid;
  if_state_e              fsm_state;

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem),
    .pc_out       (pc_out),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .fsm_state    (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE000_0000;
  endfunction

  // ---------------- memory model ----------------
  int                     mem_lat = 0;
  bit                     mem_random = 1'b0;
  bit                     pending = 1'b0;
  int                     wait_left = 0;
  logic [ADDRESS_LEN-1:0] held_addr = '0;

  initial begin
    imem.ready = 1'b0;
    imem.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) pending = 1'b0;
      if (imem.req) begin
        if (pending) begin
          check("addr_stable", imem.addr, held_addr);
        end else begin
          held_addr = imem.addr;
          wait_left = mem_random ? int'($urandom_range(0, 3)) : mem_lat;
        end
        imem.ready = (wait_left == 0);
        pending    = !imem.ready;
        if (!imem.ready) wait_left--;
      end else begin
        imem.ready = 1'b0;
        pending    = 1'b0;
      end
      imem.rdata = mem_word(imem.addr);
    end
  end

  // ---------------- scoreboard: expected program-order stream ----------------
  logic [63:0]            exp_q[$];
  logic [ADDRESS_LEN-1:0] path_next;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({path_next + 32'd4, mem_word(path_next)});
      path_next = path_next + 32'd4;
    end
  endtask

  task automatic start_path(input logic [ADDRESS_LEN-1:0] addr);
    exp_q.delete();
    path_next = addr;
    refill();
  endtask

  // ID captures the IF register on an edge without freeze or flush.
  always @(negedge clk) begin
    if (!rst && instr_valid && !freeze && !branch_taken) begin
      consumed++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=pc_out %h expected=queued entry", pc_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_pc_out", pc_out, e[63:32]);
        check("sb_instr", instruction, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
    refill();
  endtask

  task automatic do_branch(input logic [ADDRESS_LEN-1:0] addr);
    branch_taken = 1'b1;
    branch_addr  = addr;
    start_path(addr);
    step();
    branch_taken = 1'b0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n_wait;
    int consumed_start;
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    path_next    = '0;
    step();
    check("rst_pc_out", pc_out, 0);
    check("rst_instr", instruction, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_addr", imem.addr, 0);
    check("rst_state", fsm_state, IF_FETCH);
    step();

    // Zero-wait memory: one instruction per cycle.
    rst = 1'b0;
    start_path('0);
    check("zw_req", imem.req, 1);
    check("zw_addr0", imem.addr, 0);
    check("zw_valid0", instr_valid, 0);
    step();
    check("zw_pc1", pc_out, 4);
    check("zw_instr1", instruction, 32'hE000_0000);
    check("zw_valid1", instr_valid, 1);
    check("zw_addr1", imem.addr, 4);
    step();
    check("zw_pc2", pc_out, 8);
    check("zw_instr2", instruction, 32'hE000_0004);
    check("zw_addr2", imem.addr, 8);
    check("zw_ready2", imem.ready, 1);

    // Freeze at the instant address 8 is returned.
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("frz_req", imem.req, 0);
      check("frz_pc_out", pc_out, 8);
      check("frz_valid", instr_valid, 1);
    end
    check("frz_state", fsm_state, IF_HOLD);
    freeze = 1'b0;
    step();
    check("unfrz_pc_out", pc_out, 12);
    check("unfrz_instr", instruction, mem_word(32'd8));
    check("unfrz_addr", imem.addr, 12);
    check("unfrz_req", imem.req, 1);

    // Three-cycle memory from reset.
    rst = 1'b1;
    mem_lat = 2;
    step();
    rst = 1'b0;
    start_path('0);
    n_wait = 0;
    while (!imem.ready && n_wait < 10) begin
      check("w3_addr", imem.addr, 0);
      check("w3_valid", instr_valid, 0);
      step();
      n_wait++;
    end
    check("w3_wait_cycles", n_wait, 2);
    check("w3_addr_last", imem.addr, 0);
    step();
    check("w3_pc_out", pc_out, 4);
    check("w3_valid_cap", instr_valid, 1);
    check("w3_next_addr", imem.addr, 4);

    // Branch during cycle 2 of the three-cycle fetch of 0x10.
    for (int i = 0; i < 40 && imem.addr != 32'h10; i++) step();
    check("br_reach_10", imem.addr, 32'h10);
    check("br_c1_ready", imem.ready, 0);
    step();
    do_branch(32'h100);
    check("br_hold_addr", imem.addr, 32'h10);
    check("br_valid", instr_valid, 0);
    check("br_c3_ready", imem.ready, 1);
    step();
    check("br_new_addr", imem.addr, 32'h100);
    check("br_valid2", instr_valid, 0);
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    check("br_pc_out", pc_out, 32'h104);
    check("br_instr", instruction, mem_word(32'h100));

    // Branch while held with freeze high: skid contents must never appear.
    mem_lat = 0;
    for (int i = 0; i < 10 && !imem.ready; i++) step();
    check("hb_ready", imem.ready, 1);
    freeze = 1'b1;
    step();
    check("hb_state", fsm_state, IF_HOLD);
    check("hb_req", imem.req, 0);
    step();
    do_branch(32'h200);
    freeze = 1'b0;
    check("hb_valid", instr_valid, 0);
    check("hb_addr", imem.addr, 32'h200);
    check("hb_req2", imem.req, 1);
    step();
    check("hb_pc_out", pc_out, 32'h204);
    check("hb_instr", instruction, mem_word(32'h200));

    // Reset in the middle of a wait.
    mem_lat = 2;
    for (int i = 0; i < 10 && !(imem.req && !imem.ready); i++) step();
    check("mr_waiting", imem.ready, 0);
    rst = 1'b1;
    #1;
    check("mr_pc_out", pc_out, 0);
    check("mr_instr", instruction, 0);
    check("mr_valid", instr_valid, 0);
    check("mr_addr", imem.addr, 0);
    step();
    rst = 1'b0;
    start_path('0);
    check("mr_rel_addr", imem.addr, 0);
    check("mr_rel_req", imem.req, 1);

    // PC wrap at the top of the address space.
    mem_lat = 0;
    for (int i = 0; i < 10 && !imem.ready; i++) step();
    do_branch(32'hFFFF_FFFC);
    check("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    check("wrap_valid0", instr_valid, 0);
    step();
    check("wrap_next_addr", imem.addr, 0);
    check("wrap_pc_out", pc_out, 0);
    check("wrap_instr", instruction, mem_word(32'hFFFF_FFFC));
    check("wrap_valid", instr_valid, 1);

    // Random phase: random latency, freeze and branches.
    mem_random = 1'b1;
    consumed_start = consumed;
    for (int i = 0; i < 600; i++) begin
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0)
          do_branch(32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4);
        else
          do_branch($urandom & 32'hFFFF_FFFC);
      end else begin
        step();
      end
    end
    freeze = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("rand_progress", (consumed - consumed_start) > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the ARM pipeline, sitting directly upstream of the ID stage register. It owns the program counter and issues word fetches to a variable-latency instruction memory over a req/ready handshake. It presents `{pc, instruction, instr_valid}` from an internal IF register to the ID stage. It honours the pipeline `freeze` (hazard/SRAM stall) with a one-entry skid buffer, and redirects on `branch_taken` from EXE, discarding any in-flight fetch.

## Interface
- `ADDRESS_LEN`, 32, PC/address/instruction width (from shared configs header)
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `freeze`  in  1  hold IF register contents; same signal that freezes the ID stage register
- `branch_taken`  in  1  one-cycle redirect request from EXE
- `branch_addr`  in  ADDRESS_LEN  redirect target, word-aligned
- `imem_req`  out  1  fetch request; held high until `imem_ready`
- `imem_addr`  out  ADDRESS_LEN  fetch address; stable while `imem_req` high
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle (sampled only when `imem_req`=1)
- `imem_rdata`  in  32  fetched instruction
- `pc_out`  out  ADDRESS_LEN  fetch address + 4 of the presented instruction
- `instruction`  out  32  presented instruction
- `instr_valid`  out  1  presented instruction is real (0 = bubble; ID zeroes its control signals)

## Operation
- States: FETCH, HOLD, DISCARD. Reset state FETCH.
- Registers: `pc` (next fetch address), IF output register `{pc_out, instruction, instr_valid}`, skid `{skid_pc, skid_instr}`, `redirect_pc`.
- `imem_req` = 1 in FETCH and DISCARD; 0 in HOLD. `imem_addr` = `pc`.
- **FETCH:**
  - `imem_ready` & !`freeze`: IF reg ← {`pc`+4, `imem_rdata`, 1}; `pc` ← `pc`+4; stay.
  - `imem_ready` & `freeze`: skid ← {`pc`+4, `imem_rdata`}; `pc` ← `pc`+4; go HOLD. IF reg unchanged.
  - !`imem_ready` & !`freeze`: IF reg `instr_valid` ← 0, so a bubble is presented; `pc_out` and `instruction` keep their last values.
  - !`imem_ready` & `freeze`: IF reg unchanged.
- **HOLD:**
  - `freeze` low: IF reg ← {skid, valid=1}; go FETCH.
  - Otherwise hold.
- **DISCARD:** keep requesting the old address.
  - On `imem_ready`: drop the data; `pc` ← `redirect_pc`; go FETCH.
- **`branch_taken`** has priority over everything, including `freeze`:
  - IF reg `instr_valid` ← 0. Skid is invalidated.
  - In FETCH with `imem_ready`=1, or in HOLD: `pc` ← `branch_addr`; go FETCH.
  - In FETCH with `imem_ready`=0: `redirect_pc` ← `branch_addr`; go DISCARD.
  - In DISCARD: `redirect_pc` ← `branch_addr` (latest wins). If `imem_ready`=1 in the same cycle, go FETCH with `pc` ← `branch_addr`.
- PC arithmetic: ADDRESS_LEN-bit modulo add. 0xFFFFFFFC+4 wraps to 0.

## Timing
- Reset values: `pc`=RESET_PC, state FETCH, `pc_out`=0, `instruction`=0, `instr_valid`=0, skid=0, `redirect_pc`=0. `imem_req`=1 combinationally in the first cycle after reset release.
- Latency: data accepted at edge N (`imem_ready`=1, no freeze) is visible on the outputs after edge N.
- Throughput: 1 instruction/cycle when `imem_ready` is held at 1 (zero-wait memory).
- `imem_addr` must not change while `imem_req`=1 and `imem_ready`=0, including across a branch.
- Freeze response: IF reg frozen from the edge where `freeze` is sampled high. At most one instruction is buffered; no request is issued while HOLD is occupied.
- First real instruction after a redirect appears no earlier than the edge after the memory accepts `branch_addr`.
- `rst` asserted mid-fetch: all state returns to reset values immediately. The outstanding memory transaction is abandoned; memory must tolerate a dropped request.

## Structure
- Shared configs header holds `ADDRESS_LEN`, the state encodings (`IF_FETCH`, `IF_HOLD`, `IF_DISCARD`) and the word increment (4).
- The IF output register is one sub-module, `if_output_reg`:
  - priority: async reset > flush (clear valid) > load > hold
  - the FSM/PC logic stays in `if_fetch_unit`

## Test plan
- Reset, `imem_ready`≡1, memory word[a]=a^0xE000_0000: `imem_addr` 0,4,8; outputs (`pc_out`=4, `instruction`=0xE000_0000, valid) after 1st edge, then 8/0xE000_0004.
- 3-cycle memory: `imem_addr` held at 0 for 3 cycles; `instr_valid`=0 until capture; then `pc_out`=4; next `imem_addr`=4.
- `freeze`=1 for 4 cycles at the instant `imem_ready`=1 for address 8: skid filled, `imem_req`=0, outputs hold the previous instruction. After `freeze` drops: next edge shows `pc_out`=12, then fetch resumes at 12.
- `branch_taken` to 0x100 in cycle 2 of a 3-cycle fetch of 0x10: `imem_addr` stays 0x10 until ready, data dropped, `instr_valid`=0, next `imem_addr`=0x100, then `pc_out`=0x104.
- `branch_taken` to 0x200 while in HOLD with `freeze`=1: skid discarded, `instr_valid`=0, next `imem_addr`=0x200; the skid instruction never appears.
- `rst` pulsed while `imem_req`=1 mid-wait: all outputs 0 immediately; after release, `imem_addr`=RESET_PC. PC wrap check: a branch to 0xFFFF_FFFC is followed by fetch 0x0.
